// File: rtl/bcd_countdown.sv
// Four-digit BCD MM:SS countdown timer with IDLE/RUN/PAUSE/DONE control.
// Optional alarm output is built only when BCD_COUNTDOWN_ALARM_EN is defined.
module bcd_countdown #(
    parameter int unsigned ALARM_TICKS = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       CLR,
    input  logic       LD,
    input  logic [7:0] SET_M,
    input  logic [7:0] SET_S,
    input  logic       START,
    input  logic       STP,
    output logic [3:0] MH,
    output logic [3:0] ML,
    output logic [3:0] SH,
    output logic [3:0] SL,
    output logic       BO,
    output logic       DONE,
    output logic       RUNNING,
    output logic       ALM
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, FIN} state_t;

    // Digit index 3..0 = MH, ML, SH, SL.
    logic [3:0][3:0] digits_reg;
    logic [3:0][3:0] preset_reg;
    logic [3:0][3:0] set_digits;
    logic [3:0][3:0] clamp_digits;
    logic [3:0][3:0] dec_digits;
    logic [3:0]      borrow;
    state_t          state_reg;
    logic            bo_reg;
    logic            count_zero;
    logic            dec_zero;
    logic            tick_run;

    assign set_digits = {SET_M, SET_S};
    assign borrow[0]  = 1'b1;

    // Clamp each preset digit and build the ripple-borrow decrement.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        localparam logic [3:0] DIG_MAX = (gi == 1) ? 4'd5 : 4'd9;
        assign clamp_digits[gi] = (set_digits[gi] > DIG_MAX) ? DIG_MAX : set_digits[gi];
        assign dec_digits[gi]   = !borrow[gi] ? digits_reg[gi] :
                                  (digits_reg[gi] == 4'd0) ? DIG_MAX : digits_reg[gi] - 4'd1;
        if (gi < 3) begin : g_borrow
            assign borrow[gi+1] = borrow[gi] && (digits_reg[gi] == 4'd0);
        end
    end

    assign count_zero = (digits_reg == 16'h0000);
    assign dec_zero   = (digits_reg == 16'h0001);
    assign tick_run   = EN && !START && !STP && (state_reg == RUN);

    always_ff @(posedge CLK) begin
        bo_reg <= 1'b0;
        if (RST) begin
            digits_reg <= '0;
            preset_reg <= '0;
            state_reg  <= IDLE;
        end else if (CLR) begin
            digits_reg <= '0;
            state_reg  <= IDLE;
        end else if (LD) begin
            preset_reg <= clamp_digits;
            digits_reg <= clamp_digits;
            state_reg  <= IDLE;
        end else if (START) begin
            case (state_reg)
                IDLE:    if (!count_zero) state_reg <= RUN;
                PAUSE:   state_reg <= RUN;
                FIN: begin
                    digits_reg <= preset_reg;
                    state_reg  <= (preset_reg != 16'h0000) ? RUN : IDLE;
                end
                default: ;
            endcase
        end else if (STP) begin
            if (state_reg == RUN)        state_reg <= PAUSE;
            else if (state_reg == PAUSE) state_reg <= RUN;
        end else if (tick_run) begin
            digits_reg <= dec_digits;
            if (dec_zero) begin
                state_reg <= FIN;
                bo_reg    <= 1'b1;
            end
        end
    end

`ifdef BCD_COUNTDOWN_ALARM_EN
    localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);
    logic [7:0] alarm_cnt_reg;
    logic       alm_reg;

    // LD or START always leaves DONE (or was never in it), so both drop the alarm.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            alm_reg       <= 1'b0;
            alarm_cnt_reg <= '0;
        end else if (LD || START) begin
            alm_reg       <= 1'b0;
            alarm_cnt_reg <= '0;
        end else if (tick_run && dec_zero) begin
            alm_reg       <= 1'b1;
            alarm_cnt_reg <= '0;
        end else if (EN && !STP && state_reg == FIN && alm_reg) begin
            if (alarm_cnt_reg == ALARM_LAST) begin
                alm_reg       <= 1'b0;
                alarm_cnt_reg <= '0;
            end else begin
                alarm_cnt_reg <= alarm_cnt_reg + 8'd1;
            end
        end
    end

    assign ALM = alm_reg;
`else
    logic unused_alarm_cfg;
    assign unused_alarm_cfg = ^ALARM_TICKS;
    assign ALM = 1'b0;
`endif

    assign {MH, ML, SH, SL} = digits_reg;
    assign BO      = bo_reg;
    assign DONE    = (state_reg == FIN);
    assign RUNNING = (state_reg == RUN);

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed table plus randomized run of bcd_countdown against a seconds-based model.
module tb_bcd_countdown;

    localparam int TICKS = 5;
`ifdef BCD_COUNTDOWN_ALARM_EN
    localparam bit ALM_ON = 1'b1;
`else
    localparam bit ALM_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0, en = 1'b0, clr = 1'b0, ld = 1'b0, start = 1'b0, stp = 1'b0;
    logic [7:0] set_m = 8'h00, set_s = 8'h00;
    logic [3:0] mh, ml, sh, sl;
    logic       bo, done, running, alm;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bcd_countdown #(.ALARM_TICKS(TICKS)) dut (
        .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .LD(ld),
        .SET_M(set_m), .SET_S(set_s), .START(start), .STP(stp),
        .MH(mh), .ML(ml), .SH(sh), .SL(sl),
        .BO(bo), .DONE(done), .RUNNING(running), .ALM(alm)
    );

    typedef struct {
        string      name;
        logic       rst, clr, ld, start, stp, en;
        logic [7:0] sm, ss;
        logic [15:0] cnt;
        logic       bo, done, run, alm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic c, input logic l,
                       input logic [7:0] sm, input logic [7:0] ss,
                       input logic st, input logic sp, input logic e,
                       input logic [15:0] cnt, input logic b, input logic d,
                       input logic ru, input logic a);
        vec_t v;
        v.name = name; v.rst = r; v.clr = c; v.ld = l; v.sm = sm; v.ss = ss;
        v.start = st; v.stp = sp; v.en = e;
        v.cnt = cnt; v.bo = b; v.done = d; v.run = ru; v.alm = a;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic r, input logic c, input logic l,
                         input logic [7:0] sm, input logic [7:0] ss,
                         input logic st, input logic sp, input logic e);
        rst = r; clr = c; ld = l; set_m = sm; set_s = ss; start = st; stp = sp; en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] cnt, input logic b,
                         input logic d, input logic ru, input logic a);
        logic [19:0] act, exp;
        act = {mh, ml, sh, sl, bo, done, running, alm};
        exp = {cnt, b, d, ru, a};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got cnt=%h bo=%b done=%b run=%b alm=%b, want cnt=%h bo=%b done=%b run=%b alm=%b",
                     name, act[19:4], act[3], act[2], act[1], act[0], cnt, b, d, ru, a);
        end
    endtask

    // Reference model: count kept as total seconds, outputs derived arithmetically.
    int  m_preset, m_count, m_acnt;
    int  m_state; // 0 idle, 1 run, 2 pause, 3 done
    bit  m_bo, m_alm;

    function automatic int dig(input logic [3:0] d, input int lim);
        return (int'(d) > lim) ? lim : int'(d);
    endfunction

    function automatic int to_sec(input logic [7:0] m, input logic [7:0] s);
        return (dig(m[7:4], 9) * 10 + dig(m[3:0], 9)) * 60 + dig(s[7:4], 5) * 10 + dig(s[3:0], 9);
    endfunction

    function automatic logic [15:0] to_bcd(input int sec);
        int mm, ss;
        mm = sec / 60;
        ss = sec % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_step(input logic r, input logic c, input logic l,
                              input logic [7:0] sm, input logic [7:0] ss,
                              input logic st, input logic sp, input logic e);
        m_bo = 1'b0;
        if (r) begin
            m_preset = 0; m_count = 0; m_state = 0; m_alm = 0; m_acnt = 0;
        end else if (c) begin
            m_count = 0; m_state = 0; m_alm = 0; m_acnt = 0;
        end else if (l) begin
            m_preset = to_sec(sm, ss); m_count = m_preset; m_state = 0; m_alm = 0; m_acnt = 0;
        end else if (st) begin
            if (m_state == 0 && m_count != 0) m_state = 1;
            else if (m_state == 2) m_state = 1;
            else if (m_state == 3) begin
                m_count = m_preset;
                m_state = (m_preset != 0) ? 1 : 0;
                m_alm = 0; m_acnt = 0;
            end
        end else if (sp) begin
            if (m_state == 1) m_state = 2;
            else if (m_state == 2) m_state = 1;
        end else if (e) begin
            if (m_state == 1) begin
                m_count = m_count - 1;
                if (m_count == 0) begin
                    m_state = 3; m_bo = 1'b1; m_alm = ALM_ON; m_acnt = 0;
                end
            end else if (m_state == 3 && m_alm) begin
                m_acnt++;
                if (m_acnt == TICKS) m_alm = 1'b0;
            end
        end
    endtask

    initial begin
        logic [7:0] sm, ss;
        logic r, c, l, st, sp, e;
        // name rst clr ld sm ss start stp en | cnt bo done run alm
        add("reset",      1,0,0,8'h00,8'h00,0,0,0, 16'h0000,0,0,0,0);
        add("ld0003",     0,0,1,8'h00,8'h03,0,0,0, 16'h0003,0,0,0,0);
        add("start",      0,0,0,8'h00,8'h00,1,0,0, 16'h0003,0,0,1,0);
        add("tick_2",     0,0,0,8'h00,8'h00,0,0,1, 16'h0002,0,0,1,0);
        add("tick_1",     0,0,0,8'h00,8'h00,0,0,1, 16'h0001,0,0,1,0);
        add("tick_zero",  0,0,0,8'h00,8'h00,0,0,1, 16'h0000,1,1,0,ALM_ON);
        add("tick_hold",  0,0,0,8'h00,8'h00,0,0,1, 16'h0000,0,1,0,ALM_ON);
        add("idle_done",  0,0,0,8'h00,8'h00,0,0,0, 16'h0000,0,1,0,ALM_ON);
        add("ld1000",     0,0,1,8'h10,8'h00,0,0,0, 16'h1000,0,0,0,0);
        add("start1000",  0,0,0,8'h00,8'h00,1,0,0, 16'h1000,0,0,1,0);
        add("dec0959",    0,0,0,8'h00,8'h00,0,0,1, 16'h0959,0,0,1,0);
        add("ld0100",     0,0,1,8'h01,8'h00,0,0,0, 16'h0100,0,0,0,0);
        add("start0100",  0,0,0,8'h00,8'h00,1,0,0, 16'h0100,0,0,1,0);
        add("dec0059",    0,0,0,8'h00,8'h00,0,0,1, 16'h0059,0,0,1,0);
        add("clamp",      0,0,1,8'hA9,8'h7C,0,0,0, 16'h9959,0,0,0,0);
        add("ld0005",     0,0,1,8'h00,8'h05,0,0,0, 16'h0005,0,0,0,0);
        add("start0005",  0,0,0,8'h00,8'h00,1,0,0, 16'h0005,0,0,1,0);
        add("dec0004",    0,0,0,8'h00,8'h00,0,0,1, 16'h0004,0,0,1,0);
        add("pause",      0,0,0,8'h00,8'h00,0,1,0, 16'h0004,0,0,0,0);
        add("p_tick1",    0,0,0,8'h00,8'h00,0,0,1, 16'h0004,0,0,0,0);
        add("p_tick2",    0,0,0,8'h00,8'h00,0,0,1, 16'h0004,0,0,0,0);
        add("p_tick3",    0,0,0,8'h00,8'h00,0,0,1, 16'h0004,0,0,0,0);
        add("resume",     0,0,0,8'h00,8'h00,0,1,0, 16'h0004,0,0,1,0);
        add("dec0003",    0,0,0,8'h00,8'h00,0,0,1, 16'h0003,0,0,1,0);
        add("en_stp",     0,0,0,8'h00,8'h00,0,1,1, 16'h0003,0,0,0,0);
        add("p_tick4",    0,0,0,8'h00,8'h00,0,0,1, 16'h0003,0,0,0,0);
        add("start_res",  0,0,0,8'h00,8'h00,1,0,0, 16'h0003,0,0,1,0);
        add("start_stp",  0,0,0,8'h00,8'h00,1,1,0, 16'h0003,0,0,1,0);
        add("en_start",   0,0,0,8'h00,8'h00,1,0,1, 16'h0003,0,0,1,0);
        add("ld0001",     0,0,1,8'h00,8'h01,0,0,0, 16'h0001,0,0,0,0);
        add("start0001",  0,0,0,8'h00,8'h00,1,0,0, 16'h0001,0,0,1,0);
        add("done_bo",    0,0,0,8'h00,8'h00,0,0,1, 16'h0000,1,1,0,ALM_ON);
        add("alm_t1",     0,0,0,8'h00,8'h00,0,0,1, 16'h0000,0,1,0,ALM_ON);
        add("alm_t2",     0,0,0,8'h00,8'h00,0,0,1, 16'h0000,0,1,0,ALM_ON);
        add("alm_t3",     0,0,0,8'h00,8'h00,0,0,1, 16'h0000,0,1,0,ALM_ON);
        add("alm_t4",     0,0,0,8'h00,8'h00,0,0,1, 16'h0000,0,1,0,ALM_ON);
        add("alm_t5",     0,0,0,8'h00,8'h00,0,0,1, 16'h0000,0,1,0,0);
        add("alm_t6",     0,0,0,8'h00,8'h00,0,0,1, 16'h0000,0,1,0,0);
        add("restart",    0,0,0,8'h00,8'h00,1,0,0, 16'h0001,0,0,1,0);
        add("done_again", 0,0,0,8'h00,8'h00,0,0,1, 16'h0000,1,1,0,ALM_ON);
        add("alm_again",  0,0,0,8'h00,8'h00,0,0,1, 16'h0000,0,1,0,ALM_ON);
        add("clr_alarm",  0,1,0,8'h00,8'h00,0,0,1, 16'h0000,0,0,0,0);
        add("start_zero", 0,0,0,8'h00,8'h00,1,0,0, 16'h0000,0,0,0,0);
        add("ld0002",     0,0,1,8'h00,8'h02,0,0,0, 16'h0002,0,0,0,0);
        add("start0002",  0,0,0,8'h00,8'h00,1,0,0, 16'h0002,0,0,1,0);
        add("dec0001",    0,0,0,8'h00,8'h00,0,0,1, 16'h0001,0,0,1,0);
        add("rst_run",    1,0,0,8'h00,8'h00,0,0,1, 16'h0000,0,0,0,0);
        add("start_rst",  0,0,0,8'h00,8'h00,1,0,0, 16'h0000,0,0,0,0);
        add("ld0010",     0,0,1,8'h00,8'h10,0,0,0, 16'h0010,0,0,0,0);
        add("start0010",  0,0,0,8'h00,8'h00,1,0,0, 16'h0010,0,0,1,0);
        add("dec0009",    0,0,0,8'h00,8'h00,0,0,1, 16'h0009,0,0,1,0);
        add("clr_run",    0,1,0,8'h00,8'h00,0,0,1, 16'h0000,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].clr, vecs[i].ld, vecs[i].sm, vecs[i].ss,
                  vecs[i].start, vecs[i].stp, vecs[i].en);
            check(vecs[i].name, vecs[i].cnt, vecs[i].bo, vecs[i].done, vecs[i].run, vecs[i].alm);
        end

        // Randomized phase, synchronised by a reset on the first cycle.
        for (int i = 0; i < 4000; i++) begin
            r  = (i == 0) || ($urandom_range(0, 199) == 0);
            c  = ($urandom_range(0, 59) == 0);
            l  = ($urandom_range(0, 24) == 0);
            sm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            ss = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'($urandom_range(0, 1)), 4'($urandom)};
            st = ($urandom_range(0, 11) == 0);
            sp = ($urandom_range(0, 11) == 0);
            e  = ($urandom_range(0, 1) == 0);
            model_step(r, c, l, sm, ss, st, sp, e);
            apply(r, c, l, sm, ss, st, sp, e);
            check($sformatf("rand%0d", i), to_bcd(m_count), m_bo,
                  m_state == 3, m_state == 1, m_alm);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
